qam_demod_arbiter: RTL and testbench
====================================

Name: qam_demod_arbiter

Overview:
- Packet-level round-robin arbiter that shares one QAM demodulator between two Avalon-ST symbol sources, e.g. two FFT output streams.
- Sits directly upstream of the demodulator and drives its 38-bit Avalon-ST sink: real in [37:22], imag in [21:6].
- Grants one source per packet, tags each beat with its channel, and enforces packet framing.
- Includes a length watchdog and an error counter.

Parameters:
- DATA_W, 38, symbol beat width. Matches the demodulator sink.
- MAX_PKT_LEN, 64, maximum beats per packet before a forced release. Range 2..65535.
- ERR_W, 8, width of the saturating protocol-error counter.

Ports:
- clock_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- asi_in0_data  in  DATA_W  channel 0 symbol.
- asi_in0_valid  in  1  channel 0 valid.
- asi_in0_ready  out  1  channel 0 ready.
- asi_in0_startofpacket  in  1  channel 0 SOP.
- asi_in0_endofpacket  in  1  channel 0 EOP.
- asi_in1_data / valid / ready / startofpacket / endofpacket: same as channel 0, for channel 1.
- aso_out0_data  out  DATA_W  granted symbol, to the demodulator.
- aso_out0_valid  out  1  output valid.
- aso_out0_ready  in  1  demodulator ready.
- aso_out0_startofpacket  out  1  output SOP.
- aso_out0_endofpacket  out  1  output EOP. Also asserted on a forced release.
- aso_out0_channel  out  1  source channel of the current beat.
- err_count  out  ERR_W  saturating count of protocol errors.

Behaviour:
- Reset (async, active-high):
  - State IDLE, last_served=1 (channel 0 wins first).
  - beat_cnt=0, err_count=0.
  - All aso_out0_* = 0, both asi_inX_ready = 0.
- Output stage is one register.
  - load_en = !aso_out0_valid || aso_out0_ready.
  - When a beat is accepted, it appears on aso_out0_* the next cycle. Latency is 1 cycle.
  - Output holds stable while valid && !ready.
  - aso_out0_valid clears when the register drains and no new beat loads.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - Both asi_inX_ready = 1 only for beats with valid && !startofpacket on that channel. Each such beat is dropped and err_count is incremented.
  - If both channels drop a beat in the same cycle, err_count += 2, saturating.
  - A channel presenting valid && SOP is a request.
  - One request → grant that channel. Two requests → grant the channel != last_served.
  - Grant is registered. The SOP beat is accepted in the GRANT state, not in IDLE.
  - Grant takes effect the cycle after the request.
- GRANTx:
  - asi_inx_ready = load_en. The other channel's ready = 0; its requests wait.
  - On each accepted beat, beat_cnt increments.
  - Accepted beat with EOP → next state IDLE, last_served = x, beat_cnt = 0.
  - Accepted beat with beat_cnt == MAX_PKT_LEN-1 and no EOP → forced release. Output EOP is forced to 1 on that beat, err_count increments, next state IDLE, last_served = x. The remainder of that packet arrives without SOP and is dropped in IDLE as errors.
  - An SOP inside a granted packet (a missing EOP) is passed through unchanged. The watchdog bounds it.
  - A beat carrying both SOP and EOP is a single-beat packet: grant, then release after 1 beat.
- Minimum gap between packets is 1 IDLE cycle.
- err_count saturates at 2^ERR_W-1 and never wraps.
- aso_out0_channel is registered together with the data.
- Reset mid-packet: immediate return to reset values. The partial output packet is abandoned without EOP; downstream must reset together.

Test Plan:
- Single channel: ch0 sends a 4-beat packet (data 0x1..0x4, SOP on beat 1, EOP on beat 4), aso ready held at 1 → out shows 0x1..0x4 with SOP/EOP, channel=0, first valid 2 cycles after the first ch0 valid. err_count=0.
- Contention: ch0 and ch1 each present 3-beat packets continuously → grants ch0, ch1, ch0, ch1. ch1 ready stays 0 during ch0 packets. Output packets never interleave.
- Backpressure: aso ready toggles 1,0,0,1 during a 5-beat packet → output data stable while stalled. No beat is lost or duplicated. Input ready mirrors load_en.
- Orphan beats: ch1 sends 3 valid beats without SOP while IDLE → all accepted and dropped, err_count=3, no output.
- Watchdog: MAX_PKT_LEN=4, ch0 sends 6 beats with no EOP → out beat 4 has EOP=1, err_count=1 after release. Beats 5 and 6 dropped, err_count=3. ch1 is granted next if requesting.
- Reset and saturation: assert reset during beat 2 of a packet → all outputs 0 asynchronously. After release, ch0 wins the first tie. Separately, drive 300 orphan beats with ERR_W=8 → err_count holds at 255.

Source files
------------

// File: rtl/qam_demod_arbiter.sv
// qam_demod_arbiter: packet-level round-robin arbiter sharing one QAM
// demodulator between two Avalon-ST symbol sources. One source is granted per
// packet, each beat is tagged with its channel, orphan beats are dropped and
// counted, and a length watchdog force-closes runaway packets.
module qam_demod_arbiter #(
   parameter int unsigned DATA_W      = 38,
   parameter int unsigned MAX_PKT_LEN = 64,
   parameter int unsigned ERR_W       = 8
) (
   input  logic              clock_clk,
   input  logic              reset_reset,
   input  logic [DATA_W-1:0] asi_in0_data,
   input  logic              asi_in0_valid,
   output logic              asi_in0_ready,
   input  logic              asi_in0_startofpacket,
   input  logic              asi_in0_endofpacket,
   input  logic [DATA_W-1:0] asi_in1_data,
   input  logic              asi_in1_valid,
   output logic              asi_in1_ready,
   input  logic              asi_in1_startofpacket,
   input  logic              asi_in1_endofpacket,
   output logic [DATA_W-1:0] aso_out0_data,
   output logic              aso_out0_valid,
   input  logic              aso_out0_ready,
   output logic              aso_out0_startofpacket,
   output logic              aso_out0_endofpacket,
   output logic              aso_out0_channel,
   output logic [ERR_W-1:0]  err_count
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam logic [15:0] CNT_LAST = 16'(MAX_PKT_LEN - 1);

   state_t            state_q, state_d;
   logic              last_served_q, last_served_d;
   logic [15:0]       beat_cnt_q, beat_cnt_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_sop_q, out_sop_d;
   logic              out_eop_q, out_eop_d;
   logic              out_channel_q, out_channel_d;

   logic              load_en;
   logic              rdy0, rdy1;
   logic              req0, req1;
   logic              acc;
   logic              acc_ch;
   logic              acc_sop, acc_eop;
   logic [DATA_W-1:0] acc_data;
   logic [1:0]        err_inc;
   logic [ERR_W:0]    err_sum;

   // Arbitration, output-register loading, watchdog and saturating error count
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      beat_cnt_d    = beat_cnt_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_sop_d     = out_sop_q;
      out_eop_d     = out_eop_q;
      out_channel_d = out_channel_q;
      rdy0          = 1'b0;
      rdy1          = 1'b0;
      req0          = asi_in0_valid && asi_in0_startofpacket;
      req1          = asi_in1_valid && asi_in1_startofpacket;
      acc           = 1'b0;
      acc_ch        = 1'b0;
      acc_sop       = 1'b0;
      acc_eop       = 1'b0;
      acc_data      = '0;
      err_inc       = 2'd0;

      load_en = !out_valid_q || aso_out0_ready;
      if (load_en) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // Beats without SOP outside a packet are swallowed as errors;
            // SOP beats wait and are accepted once the grant is registered.
            rdy0    = asi_in0_valid && !asi_in0_startofpacket;
            rdy1    = asi_in1_valid && !asi_in1_startofpacket;
            err_inc = {1'b0, rdy0} + {1'b0, rdy1};
            if (req0 && req1) begin
               state_d = last_served_q ? GRANT0 : GRANT1;
            end else if (req0) begin
               state_d = GRANT0;
            end else if (req1) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            rdy0 = load_en;
            if (asi_in0_valid && load_en) begin
               acc      = 1'b1;
               acc_ch   = 1'b0;
               acc_sop  = asi_in0_startofpacket;
               acc_eop  = asi_in0_endofpacket;
               acc_data = asi_in0_data;
            end
         end
         GRANT1: begin
            rdy1 = load_en;
            if (asi_in1_valid && load_en) begin
               acc      = 1'b1;
               acc_ch   = 1'b1;
               acc_sop  = asi_in1_startofpacket;
               acc_eop  = asi_in1_endofpacket;
               acc_data = asi_in1_data;
            end
         end
         default: state_d = IDLE;
      endcase

      if (acc) begin
         out_valid_d   = 1'b1;
         out_data_d    = acc_data;
         out_sop_d     = acc_sop;
         out_channel_d = acc_ch;
         out_eop_d     = acc_eop;
         beat_cnt_d    = beat_cnt_q + 16'd1;
         if (acc_eop) begin
            state_d       = IDLE;
            last_served_d = acc_ch;
            beat_cnt_d    = '0;
         end else if (beat_cnt_q == CNT_LAST) begin
            // Watchdog: close the packet downstream and release the grant
            out_eop_d     = 1'b1;
            err_inc       = 2'd1;
            state_d       = IDLE;
            last_served_d = acc_ch;
            beat_cnt_d    = '0;
         end
      end

      err_sum     = {1'b0, err_count_q} + (ERR_W + 1)'(err_inc);
      err_count_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
   end

   // State, counters and the single output register
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         beat_cnt_q    <= '0;
         err_count_q   <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_sop_q     <= 1'b0;
         out_eop_q     <= 1'b0;
         out_channel_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         beat_cnt_q    <= beat_cnt_d;
         err_count_q   <= err_count_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_sop_q     <= out_sop_d;
         out_eop_q     <= out_eop_d;
         out_channel_q <= out_channel_d;
      end
   end

   // Readies are held low while reset is asserted
   assign asi_in0_ready          = rdy0 && !reset_reset;
   assign asi_in1_ready          = rdy1 && !reset_reset;
   assign aso_out0_data          = out_data_q;
   assign aso_out0_valid         = out_valid_q;
   assign aso_out0_startofpacket = out_sop_q;
   assign aso_out0_endofpacket   = out_eop_q;
   assign aso_out0_channel       = out_channel_q;
   assign err_count              = err_count_q;

endmodule

// File: tb/tb_qam_demod_arbiter.sv
// Directed bench for qam_demod_arbiter. Instance dut_a uses the default
// watchdog length, dut_b uses MAX_PKT_LEN=4; both share the source stimulus,
// and the source models follow whichever instance use_b selects.
module tb_qam_demod_arbiter;
   localparam int DW = 38;

   typedef struct packed {logic sop; logic eop; logic [DW-1:0] data;} src_t;
   typedef struct packed {logic ch; logic sop; logic eop; logic [DW-1:0] data;} out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] in0_data = '0, in1_data = '0;
   logic in0_valid = 1'b0, in0_sop = 1'b0, in0_eop = 1'b0;
   logic in1_valid = 1'b0, in1_sop = 1'b0, in1_eop = 1'b0;
   logic out_ready = 1'b1;
   logic use_b = 1'b0;

   logic a_in0_ready, a_in1_ready, a_valid, a_sop, a_eop, a_chan;
   logic b_in0_ready, b_in1_ready, b_valid, b_sop, b_eop, b_chan;
   logic [DW-1:0] a_data, b_data;
   logic [7:0] a_err, b_err;

   qam_demod_arbiter #(.DATA_W(DW), .MAX_PKT_LEN(64), .ERR_W(8)) dut_a (
      .clock_clk(clk), .reset_reset(rst),
      .asi_in0_data(in0_data), .asi_in0_valid(in0_valid), .asi_in0_ready(a_in0_ready),
      .asi_in0_startofpacket(in0_sop), .asi_in0_endofpacket(in0_eop),
      .asi_in1_data(in1_data), .asi_in1_valid(in1_valid), .asi_in1_ready(a_in1_ready),
      .asi_in1_startofpacket(in1_sop), .asi_in1_endofpacket(in1_eop),
      .aso_out0_data(a_data), .aso_out0_valid(a_valid), .aso_out0_ready(out_ready),
      .aso_out0_startofpacket(a_sop), .aso_out0_endofpacket(a_eop),
      .aso_out0_channel(a_chan), .err_count(a_err)
   );

   qam_demod_arbiter #(.DATA_W(DW), .MAX_PKT_LEN(4), .ERR_W(8)) dut_b (
      .clock_clk(clk), .reset_reset(rst),
      .asi_in0_data(in0_data), .asi_in0_valid(in0_valid), .asi_in0_ready(b_in0_ready),
      .asi_in0_startofpacket(in0_sop), .asi_in0_endofpacket(in0_eop),
      .asi_in1_data(in1_data), .asi_in1_valid(in1_valid), .asi_in1_ready(b_in1_ready),
      .asi_in1_startofpacket(in1_sop), .asi_in1_endofpacket(in1_eop),
      .aso_out0_data(b_data), .aso_out0_valid(b_valid), .aso_out0_ready(out_ready),
      .aso_out0_startofpacket(b_sop), .aso_out0_endofpacket(b_eop),
      .aso_out0_channel(b_chan), .err_count(b_err)
   );

   src_t q0[$], q1[$];
   out_t qa[$], qb[$];
   int n_pass = 0, n_total = 0;
   int cyc = 0, in0_rise = -1, a_first = -1;
   int stall_err = 0, both_rdy = 0;
   logic [7:0] b_err_eop = '0;
   logic stall_pend = 1'b0;
   logic [DW+3:0] stall_snap = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Source model, channel 0: holds each beat until it is handshaken
   always begin : bfm0
      logic hs;
      @(negedge clk);
      hs = in0_valid && (use_b ? b_in0_ready : a_in0_ready);
      @(posedge clk);
      #1;
      if (rst) in0_rise = -1;
      if (hs && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
         if (!in0_valid && in0_rise < 0) in0_rise = cyc;
         in0_valid = 1'b1;
         {in0_sop, in0_eop, in0_data} = q0[0];
      end else begin
         in0_valid = 1'b0; in0_sop = 1'b0; in0_eop = 1'b0;
      end
   end

   // Source model, channel 1
   always begin : bfm1
      logic hs;
      @(negedge clk);
      hs = in1_valid && (use_b ? b_in1_ready : a_in1_ready);
      @(posedge clk);
      #1;
      if (hs && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
         in1_valid = 1'b1;
         {in1_sop, in1_eop, in1_data} = q1[0];
      end else begin
         in1_valid = 1'b0; in1_sop = 1'b0; in1_eop = 1'b0;
      end
   end

   // Output monitor: records transfers and watches stall stability
   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
         qb.delete();
         a_first    <= -1;
         stall_err  <= 0;
         both_rdy   <= 0;
         b_err_eop  <= '0;
         stall_pend <= 1'b0;
      end else begin
         if (a_valid && out_ready) begin
            qa.push_back({a_chan, a_sop, a_eop, a_data});
            if (a_first < 0) a_first <= cyc;
         end
         if (b_valid && out_ready) begin
            qb.push_back({b_chan, b_sop, b_eop, b_data});
            if (b_eop && !b_chan) b_err_eop <= b_err;
         end
         if (stall_pend && {a_valid, a_chan, a_sop, a_eop, a_data} !== stall_snap)
            stall_err <= stall_err + 1;
         stall_pend <= a_valid && !out_ready;
         stall_snap <= {a_valid, a_chan, a_sop, a_eop, a_data};
         if (a_in0_ready && a_in1_ready) both_rdy <= both_rdy + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input bit sel_b, input int i,
                           input logic c, input logic s, input logic e, input logic [DW-1:0] d);
      out_t got;
      if (sel_b) got = (i < qb.size()) ? qb[i] : '0;
      else       got = (i < qa.size()) ? qa[i] : '0;
      chk($sformatf("%s[%0d]", tag, i), 64'(got), 64'({c, s, e, d}));
   endtask

   task automatic push0(input logic s, input logic e, input logic [DW-1:0] d);
      q0.push_back({s, e, d});
   endtask

   task automatic push1(input logic s, input logic e, input logic [DW-1:0] d);
      q1.push_back({s, e, d});
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
   endtask

   // Waits (bounded) for n transfers, lets extra beats show up, then checks the count
   task automatic wait_out(input bit sel_b, input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (((sel_b ? qb.size() : qa.size()) < n) && i < budget) begin
         @(posedge clk); i++;
      end
      repeat (4) @(posedge clk);
      chk(tag, sel_b ? qb.size() : qa.size(), n);
   endtask

   task automatic wait_src(input int budget, input string tag);
      int i;
      i = 0;
      while ((q0.size() + q1.size()) > 0 && i < budget) begin
         @(posedge clk); i++;
      end
      repeat (3) @(posedge clk);
      chk(tag, q0.size() + q1.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin : stim
      logic [DW-1:0] ev [12];
      logic [3:0] pat;
      logic [DW-1:0] pdat [4];
      int i;

      // Reset state, including ready gating for an orphan beat during reset
      repeat (2) @(posedge clk);
      #2;
      in1_valid = 1'b1; in1_sop = 1'b0;
      #1;
      chk("rst_valid", a_valid, 0);
      chk("rst_data", a_data, 0);
      chk("rst_sopeop", {a_sop, a_eop, a_chan}, 0);
      chk("rst_err", a_err, 0);
      chk("rst_ready", {a_in0_ready, a_in1_ready}, 0);
      in1_valid = 1'b0;
      @(posedge clk); #3 rst = 1'b0;

      // Single channel packet, latency 2 from first input valid
      push0(1, 0, 38'h1); push0(0, 0, 38'h2); push0(0, 0, 38'h3); push0(0, 1, 38'h4);
      wait_out(0, 4, 40, "t1_count");
      chk_beat("t1_beat", 0, 0, 0, 1, 0, 38'h1);
      chk_beat("t1_beat", 0, 1, 0, 0, 0, 38'h2);
      chk_beat("t1_beat", 0, 2, 0, 0, 0, 38'h3);
      chk_beat("t1_beat", 0, 3, 0, 0, 1, 38'h4);
      chk("t1_latency", a_first - in0_rise, 2);
      chk("t1_err", a_err, 0);

      // Contention: alternating grants, no interleaving
      do_reset();
      push0(1, 0, 38'h101); push0(0, 0, 38'h102); push0(0, 1, 38'h103);
      push0(1, 0, 38'h104); push0(0, 0, 38'h105); push0(0, 1, 38'h106);
      push1(1, 0, 38'h201); push1(0, 0, 38'h202); push1(0, 1, 38'h203);
      push1(1, 0, 38'h204); push1(0, 0, 38'h205); push1(0, 1, 38'h206);
      ev = '{38'h101, 38'h102, 38'h103, 38'h201, 38'h202, 38'h203,
             38'h104, 38'h105, 38'h106, 38'h204, 38'h205, 38'h206};
      wait_out(0, 12, 100, "t2_count");
      for (int k = 0; k < 12; k++)
         chk_beat("t2_beat", 0, k, 1'((k / 3) % 2), (k % 3) == 0, (k % 3) == 2, ev[k]);
      chk("t2_both_ready", both_rdy, 0);
      chk("t2_err", a_err, 0);

      // Backpressure: ready 1,0,0,1 while the packet flows
      do_reset();
      out_ready = 1'b1;
      push0(1, 0, 38'h11); push0(0, 0, 38'h12); push0(0, 0, 38'h13);
      push0(0, 0, 38'h14); push0(0, 1, 38'h15);
      i = 0;
      while (!a_valid && i < 30) begin
         @(posedge clk); #1; i++;
      end
      chk("t3_first_valid", a_valid, 1);
      pat  = 4'b1001;
      pdat = '{38'h11, 38'h12, 38'h12, 38'h12};
      for (int k = 0; k < 4; k++) begin
         out_ready = pat[3-k];
         #1;
         chk($sformatf("t3_in_ready[%0d]", k), a_in0_ready, pat[3-k]);
         chk($sformatf("t3_data[%0d]", k), a_data, pdat[k]);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_out(0, 5, 40, "t3_count");
      chk_beat("t3_beat", 0, 0, 0, 1, 0, 38'h11);
      chk_beat("t3_beat", 0, 1, 0, 0, 0, 38'h12);
      chk_beat("t3_beat", 0, 2, 0, 0, 0, 38'h13);
      chk_beat("t3_beat", 0, 3, 0, 0, 0, 38'h14);
      chk_beat("t3_beat", 0, 4, 0, 0, 1, 38'h15);
      chk("t3_stall_stable", stall_err, 0);

      // Orphan beats: single channel, then both channels together
      do_reset();
      push1(0, 0, 38'h31); push1(0, 0, 38'h32); push1(0, 0, 38'h33);
      wait_src(30, "t4_drain1");
      chk("t4_err3", a_err, 3);
      chk("t4_no_out", qa.size(), 0);
      push0(0, 0, 38'h34); push0(0, 0, 38'h35);
      push1(0, 0, 38'h36); push1(0, 1, 38'h37);
      wait_src(30, "t4_drain2");
      chk("t4_err7", a_err, 7);
      chk("t4_no_out2", qa.size(), 0);

      // Watchdog on the MAX_PKT_LEN=4 instance
      do_reset();
      use_b = 1'b1;
      push0(1, 0, 38'h41); push0(0, 0, 38'h42); push0(0, 0, 38'h43);
      push0(0, 0, 38'h44); push0(0, 0, 38'h45); push0(0, 0, 38'h46);
      push1(1, 0, 38'h51); push1(0, 1, 38'h52);
      wait_out(1, 6, 60, "t5_count");
      chk_beat("t5_beat", 1, 0, 0, 1, 0, 38'h41);
      chk_beat("t5_beat", 1, 1, 0, 0, 0, 38'h42);
      chk_beat("t5_beat", 1, 2, 0, 0, 0, 38'h43);
      chk_beat("t5_beat", 1, 3, 0, 0, 1, 38'h44);
      chk_beat("t5_beat", 1, 4, 1, 1, 0, 38'h51);
      chk_beat("t5_beat", 1, 5, 1, 0, 1, 38'h52);
      chk("t5_err_at_release", b_err_eop, 1);
      wait_src(30, "t5_drain");
      chk("t5_err_final", b_err, 3);

      // Reset mid-packet, then channel 0 wins the first tie
      do_reset();
      use_b = 1'b0;
      push0(1, 0, 38'h61); push0(0, 0, 38'h62); push0(0, 0, 38'h63); push0(0, 1, 38'h64);
      i = 0;
      while (!(a_valid && a_data == 38'h62) && i < 30) begin
         @(posedge clk); #1; i++;
      end
      chk("t6_beat2_seen", a_data, 38'h62);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", a_valid, 0);
      chk("t6_rst_data", a_data, 0);
      chk("t6_rst_flags", {a_sop, a_eop, a_chan}, 0);
      chk("t6_rst_in_ready", a_in0_ready, 0);
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      push0(1, 1, 38'h71);
      push1(1, 1, 38'h81);
      wait_out(0, 2, 30, "t6_count");
      chk_beat("t6_tie", 0, 0, 0, 1, 1, 38'h71);
      chk_beat("t6_tie", 0, 1, 1, 1, 1, 38'h81);

      // Saturation: 300 orphan beats, two per cycle
      do_reset();
      for (int k = 0; k < 150; k++) begin
         push0(0, 0, DW'(k));
         push1(0, 0, DW'(k + 1000));
      end
      wait_src(400, "t7_drain");
      chk("t7_err_sat", a_err, 255);
      chk("t7_no_out", qa.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
